// File: rtl/shift32_seq_ctrl.sv
// Command sequencer driving a 32-bit universal shift register (load, rotate-by-N, serialize/deserialize).
// Optional abort support is enabled by defining SHIFT32_SEQ_ABORT_EN.
`timescale 1ns/1ps
module shift32_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             reg_enb,
    output logic [1:0]       reg_mode,
    output logic             reg_dir,
    output logic             reg_s_in,
    output logic [WIDTH-1:0] reg_d,
    input  logic [WIDTH-1:0] reg_q,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    input  logic             ser_in,
    input  logic             ser_in_valid,
    output logic             ser_in_ready,
    output logic             busy,
    output logic             done
`ifdef SHIFT32_SEQ_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    // Wide enough for both cnt+1 (up to 2^CNT_W) and WIDTH without early wrap.
    localparam int unsigned CW = ((CNT_W + 1) > ($clog2(WIDTH) + 1)) ? (CNT_W + 1)
                                                                       : ($clog2(WIDTH) + 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StRot, StSoLd, StSo, StSin, StDone
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic             dir_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             abort_act;
    logic             active;

    assign active = (state_q != StIdle) && (state_q != StDone);

`ifdef SHIFT32_SEQ_ABORT_EN
    logic aborted_q;
    assign abort_act = abort & active;
    assign aborted   = aborted_q;
`else
    assign abort_act = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef SHIFT32_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        dir_q   <= cmd_dir;
                        cnt_q   <= cmd_cnt;
                        data_q  <= cmd_data;
                        count_q <= '0;
                        unique case (cmd_op)
                            2'b00:   state_q <= StLoad;
                            2'b01:   state_q <= StRot;
                            2'b10:   state_q <= StSoLd;
                            default: state_q <= StSin;
                        endcase
                    end
                end
                StLoad: state_q <= StDone;
                StRot: begin
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(cnt_q)) state_q <= StDone;
                end
                StSoLd: begin
                    count_q <= '0;
                    state_q <= StSo;
                end
                StSo: begin
                    if (ser_ready) begin
                        count_q <= count_q + 1'b1;
                        if (count_q == CW'(WIDTH - 1)) state_q <= StDone;
                    end
                end
                StSin: begin
                    if (ser_in_valid) begin
                        count_q <= count_q + 1'b1;
                        if (count_q == CW'(cnt_q)) state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
`ifdef SHIFT32_SEQ_ABORT_EN
                    aborted_q <= 1'b0;
`endif
                end
                default: state_q <= StIdle;
            endcase
            if (abort_act) begin
                state_q <= StDone;
`ifdef SHIFT32_SEQ_ABORT_EN
                aborted_q <= 1'b1;
`endif
            end
        end
    end

    always_comb begin
        reg_enb      = 1'b0;
        reg_mode     = 2'b11;
        reg_dir      = 1'b0;
        reg_s_in     = 1'b0;
        reg_d        = '0;
        ser_out      = 1'b0;
        ser_valid    = 1'b0;
        ser_in_ready = 1'b0;
        case (state_q)
            StLoad, StSoLd: begin
                reg_enb  = 1'b1;
                reg_mode = 2'b10;
                reg_d    = data_q;
            end
            StRot: begin
                reg_enb  = 1'b1;
                reg_mode = 2'b01;
                reg_dir  = dir_q;
            end
            StSo: begin
                reg_enb   = ser_ready;
                reg_mode  = 2'b00;
                reg_dir   = dir_q;
                ser_valid = 1'b1;
                ser_out   = dir_q ? reg_q[0] : reg_q[WIDTH-1];
            end
            StSin: begin
                reg_enb      = ser_in_valid;
                reg_mode     = 2'b00;
                reg_dir      = dir_q;
                reg_s_in     = ser_in;
                ser_in_ready = 1'b1;
            end
            default: ;
        endcase
        if (abort_act) reg_enb = 1'b0;
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_shift32_seq_ctrl.sv
// Scoreboard bench for shift32_seq_ctrl with a behavioural model of the 32-bit shift register.
// Abort checks are compiled in when SHIFT32_SEQ_ABORT_EN is defined.
`timescale 1ns/1ps
module tb_shift32_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_data;
    logic             reg_enb;
    logic [1:0]       reg_mode;
    logic             reg_dir;
    logic             reg_s_in;
    logic [WIDTH-1:0] reg_d;
    logic [WIDTH-1:0] reg_q;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_in;
    logic             ser_in_valid;
    logic             ser_in_ready;
    logic             busy;
    logic             done;
`ifdef SHIFT32_SEQ_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    always #5 clk = ~clk;

    shift32_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_dir      (cmd_dir),
        .cmd_cnt      (cmd_cnt),
        .cmd_data     (cmd_data),
        .reg_enb      (reg_enb),
        .reg_mode     (reg_mode),
        .reg_dir      (reg_dir),
        .reg_s_in     (reg_s_in),
        .reg_d        (reg_d),
        .reg_q        (reg_q),
        .ser_out      (ser_out),
        .ser_valid    (ser_valid),
        .ser_ready    (ser_ready),
        .ser_in       (ser_in),
        .ser_in_valid (ser_in_valid),
        .ser_in_ready (ser_in_ready),
        .busy         (busy),
        .done         (done)
`ifdef SHIFT32_SEQ_ABORT_EN
        ,
        .abort        (abort),
        .aborted      (aborted)
`endif
    );

    // External universal shift register model (not reset, like the real part).
    always @(posedge clk) begin
        if (reg_enb) begin
            case (reg_mode)
                2'b00: reg_q <= reg_dir ? {reg_s_in, reg_q[WIDTH-1:1]}
                                        : {reg_q[WIDTH-2:0], reg_s_in};
                2'b01: reg_q <= reg_dir ? {reg_q[0], reg_q[WIDTH-1:1]}
                                        : {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
                2'b10: reg_q <= reg_d;
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [WIDTH-1:0] q;
        int               enb;
        int               lat;
        logic             abrt;
    } exp_t;

    exp_t             exp_done[$];
    logic             exp_bits[$];
    logic [WIDTH-1:0] cur_data;
    int               n_checks = 0;
    int               n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, pops expectations whenever the DUT presents output.
    int cyc = 0;
    int acc_cyc = 0;
    int enb_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            exp_t e;
            logic b;
            cyc++;
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc;
                enb_cnt = 0;
            end
            if (reg_enb) enb_cnt++;
            if (reg_enb && reg_mode == 2'b10) check("load_d", 64'(reg_d), 64'(cur_data));
            if (ser_valid) begin
                check("so_enb_tracks_ready", 64'(reg_enb), 64'(ser_ready));
                check("so_mode", 64'(reg_mode), 64'(2'b00));
                if (ser_ready) begin
                    if (exp_bits.size() == 0) begin
                        check("unexpected_ser_bit", 64'(exp_bits.size()), 64'd1);
                    end else begin
                        b = exp_bits.pop_front();
                        check("ser_out_bit", 64'(ser_out), 64'(b));
                    end
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 64'(exp_done.size()), 64'd1);
                end else begin
                    e = exp_done.pop_front();
                    check("done_q", 64'(reg_q), 64'(e.q));
                    check("done_enb_cycles", 64'(enb_cnt), 64'(e.enb));
                    if (e.lat >= 0) check("done_latency", 64'(cyc - acc_cyc), 64'(e.lat));
`ifdef SHIFT32_SEQ_ABORT_EN
                    check("done_aborted", 64'(aborted), 64'(e.abrt));
`endif
                end
            end
        end
    end

    task automatic push_exp(input logic [WIDTH-1:0] q, input int enb, input int lat,
                            input logic abrt);
        exp_t e;
        e.q = q;
        e.enb = enb;
        e.lat = lat;
        e.abrt = abrt;
        exp_done.push_back(e);
    endtask

    task automatic send(input logic [1:0] op, input logic dir, input logic [CNT_W-1:0] cnt,
                        input logic [WIDTH-1:0] data);
        cur_data  = data;
        cmd_op    = op;
        cmd_dir   = dir;
        cmd_cnt   = cnt;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        logic got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        check(name, 64'(got), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] so_data;
        logic [7:0]       sin_bits;
        logic             got;
        int               idx;

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_dir = 1'b0;
        cmd_cnt = '0;
        cmd_data = '0;
        ser_ready = 1'b0;
        ser_in = 1'b0;
        ser_in_valid = 1'b0;
`ifdef SHIFT32_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        check("rst_enb", 64'(reg_enb), 64'd0);
        check("rst_mode", 64'(reg_mode), 64'(2'b11));
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ser_valid", 64'(ser_valid), 64'd0);
        check("rst_ser_in_ready", 64'(ser_in_ready), 64'd0);
        check("rst_reg_d", 64'(reg_d), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // LOAD
        push_exp(32'hDEADBEEF, 1, 2, 1'b0);
        send(2'b00, 1'b0, '0, 32'hDEADBEEF);
        wait_done("load_done", 10);

        // ROTATE left by 4, then full rotation
        push_exp(32'h80000001, 1, 2, 1'b0);
        send(2'b00, 1'b0, '0, 32'h80000001);
        wait_done("load2_done", 10);
        push_exp(32'h00000018, 4, 5, 1'b0);
        send(2'b01, 1'b0, 5'd3, '0);
        check("rot_busy", 64'(busy), 64'd1);
        check("rot_cmd_ready", 64'(cmd_ready), 64'd0);
        wait_done("rot4_done", 20);
        push_exp(32'h00000018, 32, 33, 1'b0);
        send(2'b01, 1'b0, 5'd31, '0);
        wait_done("rot32_done", 50);

        // SHIFT_OUT MSB first with ready low every third cycle
        so_data = 32'hA5000003;
        for (int i = WIDTH - 1; i >= 0; i--) exp_bits.push_back(so_data[i]);
        push_exp(32'h00000000, 33, -1, 1'b0);
        send(2'b10, 1'b0, '0, so_data);
        got = 1'b0;
        for (int i = 0; i < 120 && !got; i++) begin
            ser_ready = (i % 3 != 2);
            @(negedge clk);
            got = done;
            if (!got) begin
                @(posedge clk);
                #1;
            end
        end
        check("so_done", 64'(got), 64'd1);
        check("so_bits_left", 64'(exp_bits.size()), 64'd0);
        @(posedge clk);
        #1 ser_ready = 1'b0;

        // SHIFT_IN right, 8 bits with valid gaps
        sin_bits = 8'h4D;
        push_exp(32'h4D000000, 8, -1, 1'b0);
        send(2'b11, 1'b1, 5'd7, '0);
        idx = 0;
        for (int i = 0; i < 40 && idx < 8; i++) begin
            ser_in_valid = (i % 3 != 1);
            ser_in = sin_bits[idx];
            @(posedge clk);
            #1;
            if (i % 3 != 1) idx++;
        end
        ser_in_valid = 1'b0;
        wait_done("sin_done", 10);

        // Reset in the middle of a long rotate
        send(2'b01, 1'b0, 5'd20, '0);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_enb", 64'(reg_enb), 64'd0);
        check("midrst_mode", 64'(reg_mode), 64'(2'b11));
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        push_exp(32'h12345678, 1, 2, 1'b0);
        send(2'b00, 1'b0, '0, 32'h12345678);
        wait_done("post_rst_load_done", 10);

`ifdef SHIFT32_SEQ_ABORT_EN
        // Abort a serialize after 10 accepted bits
        for (int i = WIDTH - 1; i >= WIDTH - 10; i--) exp_bits.push_back(so_data[i]);
        push_exp(32'h00000C00, 11, -1, 1'b1);
        ser_ready = 1'b1;
        send(2'b10, 1'b0, '0, so_data);
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        abort = 1'b1;
        ser_ready = 1'b0;
        #1;
        check("abort_enb", 64'(reg_enb), 64'd0);
        wait_done("abort_done", 5);
        abort = 1'b0;
        check("abort_idle", 64'(cmd_ready), 64'd1);
`endif

        check("exp_done_left", 64'(exp_done.size()), 64'd0);
        check("exp_bits_left", 64'(exp_bits.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
